// File: rtl/apb_fetch_unit.sv
// apb_fetch_unit: APB read-only instruction fetch master that feeds the
// prefetch buffer with 16-bit instruction pairs.
// Optional feature macro: FETCH_ERR_EN. When it is defined, pslverr is
// honoured, fetch_err becomes a sticky error flag and a terminal ERR state
// exists. When it is undefined, pslverr is ignored and fetch_err is tied low.
module apb_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       NOP_INST = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_flg,
  input  logic              redir,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [15:0]       inst1,
  output logic [15:0]       inst2,
  output logic              write,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DELIVER = 3'd3
`ifdef FETCH_ERR_EN
    , ERR   = 3'd4
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fa_reg, fa_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              half_reg, half_next;
  logic              discard_reg, discard_next;
  logic [15:0]       inst1_reg, inst1_next;
  logic [15:0]       inst2_reg, inst2_next;

  // Lower and upper halfword of the read word, in program order.
  logic [15:0] pr_half [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign pr_half[gi] = prdata[gi*16 +: 16];
  end

  logic xfer_done;  // APB transfer completes on this edge
  logic consume;    // downstream takes the pending pair on this edge
  logic start;      // a new transfer begins on this edge
  logic err_hit;    // a kept transfer reports a slave error
  logic in_err;     // locked in the error state
  logic keep;       // completed word is delivered downstream

  assign xfer_done = (state_reg == ACCESS) && pready;
  assign consume   = (state_reg == DELIVER) && !stall_flg;
  assign start     = (state_reg == IDLE) && !stall_flg && !redir;

`ifdef FETCH_ERR_EN
  // A redirect on the completing edge discards the word, so its error is moot.
  assign err_hit = xfer_done && pslverr && !discard_reg && !redir;
  assign in_err  = (state_reg == ERR);
  logic unused_bits;
  assign unused_bits = redir_addr[0];
`else
  assign err_hit = 1'b0;
  assign in_err  = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{redir_addr[0], pslverr};
`endif

  assign keep = xfer_done && !discard_reg && !redir && !err_hit;

  // State and datapath registers; reset restarts fetching from RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      fa_reg      <= RESET_PC;
      paddr_reg   <= '0;
      half_reg    <= 1'b0;
      discard_reg <= 1'b0;
      inst1_reg   <= '0;
      inst2_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      fa_reg      <= fa_next;
      paddr_reg   <= paddr_next;
      half_reg    <= half_next;
      discard_reg <= discard_next;
      inst1_reg   <= inst1_next;
      inst2_reg   <= inst2_next;
    end
  end

  // Next-state logic: one transfer at a time, then hand the pair downstream.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (keep)        state_next = DELIVER;
        else if (pready) state_next = IDLE;
`ifdef FETCH_ERR_EN
        if (err_hit)     state_next = ERR;
`endif
      end
      DELIVER: if (consume || redir) state_next = IDLE;
`ifdef FETCH_ERR_EN
      ERR:     state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: fetch address, odd-halfword entry and discard tracking.
  always_comb begin
    fa_next      = fa_reg;
    paddr_next   = paddr_reg;
    half_next    = half_reg;
    discard_next = discard_reg;
    inst1_next   = inst1_reg;
    inst2_next   = inst2_reg;

    if (start) paddr_next = fa_reg;

    if (xfer_done) discard_next = 1'b0;

    if (keep) begin
      if (half_reg) begin
        // Redirect landed on the upper halfword: skip the lower one.
        inst1_next = pr_half[1];
        inst2_next = NOP_INST;
        half_next  = 1'b0;
      end else begin
        inst1_next = pr_half[0];
        inst2_next = pr_half[1];
      end
      fa_next = fa_reg + ADDR_W'(4);
    end

    // A redirect wins over sequential advance; an in-flight transfer
    // still finishes on the bus but its data will be thrown away.
    if (redir && !in_err) begin
      fa_next   = {redir_addr[ADDR_W-1:2], 2'b00};
      half_next = redir_addr[1];
      if ((state_reg == SETUP) || ((state_reg == ACCESS) && !pready))
        discard_next = 1'b1;
    end
  end

  // Output decode: bus strobes and pair-valid follow the state directly.
  always_comb begin
    psel    = (state_reg == SETUP) || (state_reg == ACCESS);
    penable = (state_reg == ACCESS);
    write   = (state_reg == DELIVER);
    pwrite  = 1'b0;
    paddr   = paddr_reg;
    inst1   = inst1_reg;
    inst2   = inst2_reg;
`ifdef FETCH_ERR_EN
    fetch_err = (state_reg == ERR);
`else
    fetch_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_apb_fetch_unit.sv
// tb_apb_fetch_unit: directed table, hand-written corner sequences and a
// randomized run checked against a program-counter level reference model.
`timescale 1ns/1ps
module tb_apb_fetch_unit;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP_INST = 16'h4E71;

  logic        clk;
  logic        rst;
  logic        stall_flg;
  logic        redir;
  logic [15:0] redir_addr;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [15:0] inst1;
  logic [15:0] inst2;
  logic        write;
  logic        fetch_err;

  apb_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_flg  (stall_flg),
    .redir      (redir),
    .redir_addr (redir_addr),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .inst1      (inst1),
    .inst2      (inst2),
    .write      (write),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // ---------------- APB slave model ----------------
  int unsigned wait_cfg;
  bit          err_cfg;
  int unsigned acc_cnt;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'hBBBB_AAAA;
    return {a ^ 16'hC3C3, a ^ 16'h3C3C};
  endfunction

  assign prdata  = mem_word(paddr);
  assign pready  = penable && (acc_cnt >= wait_cfg);
  assign pslverr = err_cfg && pready;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  // ---------------- reference model and checking ----------------
  logic [15:0] m_pc;
  bit          m_half;
  int          n_cmp, n_bad, n_cons;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: called at negedge with inputs already driven.
  task automatic tick();
    logic p_write, p_sel, p_en, p_rdy, p_rst, p_stall, p_redir;
    logic [15:0] p_i1, p_i2, p_addr;
    logic [31:0] w, e;
    #1;
    p_write = write; p_sel = psel; p_en = penable; p_rdy = pready;
    p_rst = rst; p_stall = stall_flg; p_redir = redir;
    p_i1 = inst1; p_i2 = inst2; p_addr = paddr;
    if (rst) begin
      m_pc = RESET_PC;
      m_half = 1'b0;
    end else begin
      if (write && !stall_flg) begin
        w = mem_word(m_pc);
        e = m_half ? {NOP_INST, w[31:16]} : w;
        chk("pair", {inst2, inst1}, e);
        $display("pair %0d: fa=%h inst1=%h inst2=%h", n_cons, m_pc, inst1, inst2);
        n_cons++;
        m_pc = m_pc + 16'd4;
        m_half = 1'b0;
      end
      if (redir) begin
        m_pc = {redir_addr[15:2], 2'b00};
        m_half = redir_addr[1];
      end
    end
    @(posedge clk);
    #1;
    if (!p_rst) begin
      chk("pwrite", pwrite, 0);
      if (write) chk("no_psel_while_write", psel, 0);
      if (psel)  chk("paddr_align", paddr[1:0], 0);
      if (p_sel && p_en && !p_rdy) begin
        chk("wait_strobes", {psel, penable}, 2'b11);
        chk("wait_paddr", paddr, p_addr);
      end
      if (p_write && p_stall && !p_redir) begin
        chk("stall_write", write, 1);
        chk("stall_pair", {inst2, inst1}, {p_i2, p_i1});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; stall_flg = 0; redir = 0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run_to_write(input string name, input int budget);
    int k;
    k = 0;
    stall_flg = 0; redir = 0;
    while (!write && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_write_seen"}, write, 1);
  endtask

  task automatic next_setup(input string name, input logic [15:0] exp, input int budget);
    int k;
    k = 0;
    stall_flg = 0; redir = 0;
    do begin
      tick();
      k++;
    end while (!(psel && !penable) && k < budget);
    chk({name, "_setup"}, psel && !penable, 1);
    chk({name, "_paddr"}, paddr, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          st;
    bit          rd;
    logic [15:0] ra;
    bit          e_psel;
    bit          e_pen;
    bit          e_write;
    logic [15:0] e_paddr;
    logic [15:0] e_i1;
    logic [15:0] e_i2;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  function automatic vec_t mk(input bit st, input bit rd, input logic [15:0] ra,
                              input bit ps, input bit pe, input bit wr,
                              input logic [15:0] pa, input logic [15:0] i1,
                              input logic [15:0] i2);
    vec_t v;
    v.st = st; v.rd = rd; v.ra = ra;
    v.e_psel = ps; v.e_pen = pe; v.e_write = wr;
    v.e_paddr = pa; v.e_i1 = i1; v.e_i2 = i2;
    return v;
  endfunction

  initial begin
    logic [31:0] w4, w10;
    int k;
    int c0;
    clk = 0; rst = 1; stall_flg = 0; redir = 0; redir_addr = '0;
    wait_cfg = 0; err_cfg = 0;
    n_cmp = 0; n_bad = 0; n_cons = 0;
    m_pc = RESET_PC; m_half = 0;

    w4  = mem_word(16'h0004);
    w10 = mem_word(16'h0010);
    // st rd ra | psel pen write | paddr inst1 inst2
    tv[0]  = mk(0, 0, 16'h0,  1, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[1]  = mk(0, 0, 16'h0,  1, 1, 0, 16'h0000, 16'h0, 16'h0);
    tv[2]  = mk(0, 0, 16'h0,  0, 0, 1, 16'h0000, 16'hAAAA, 16'hBBBB);
    tv[3]  = mk(0, 0, 16'h0,  0, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[4]  = mk(0, 0, 16'h0,  1, 0, 0, 16'h0004, 16'h0, 16'h0);
    tv[5]  = mk(0, 0, 16'h0,  1, 1, 0, 16'h0004, 16'h0, 16'h0);
    tv[6]  = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[7]  = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[8]  = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[9]  = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[10] = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[11] = mk(1, 0, 16'h0,  0, 0, 1, 16'h0004, w4[15:0], w4[31:16]);
    tv[12] = mk(0, 0, 16'h0,  0, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[13] = mk(1, 0, 16'h0,  0, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[14] = mk(0, 0, 16'h0,  1, 0, 0, 16'h0008, 16'h0, 16'h0);
    tv[15] = mk(0, 0, 16'h0,  1, 1, 0, 16'h0008, 16'h0, 16'h0);
    tv[16] = mk(0, 1, 16'h12, 0, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[17] = mk(0, 0, 16'h0,  1, 0, 0, 16'h0010, 16'h0, 16'h0);
    tv[18] = mk(0, 0, 16'h0,  1, 1, 0, 16'h0010, 16'h0, 16'h0);
    tv[19] = mk(0, 0, 16'h0,  0, 0, 1, 16'h0010, w10[31:16], NOP_INST);
    tv[20] = mk(0, 0, 16'h0,  0, 0, 0, 16'h0000, 16'h0, 16'h0);
    tv[21] = mk(0, 0, 16'h0,  1, 0, 0, 16'h0014, 16'h0, 16'h0);

    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_ctl", {psel, penable, write, fetch_err}, 4'b0000);
    chk("rst_paddr", paddr, 16'h0000);
    chk("rst_inst", {inst1, inst2}, 32'h0);

    // T1/T2/T4 cycle-accurate table
    for (int i = 0; i < NV; i++) begin
      stall_flg = tv[i].st; redir = tv[i].rd; redir_addr = tv[i].ra;
      tick();
      chk($sformatf("v%0d_ctl", i), {psel, penable, write},
          {tv[i].e_psel, tv[i].e_pen, tv[i].e_write});
      if (tv[i].e_psel)  chk($sformatf("v%0d_paddr", i), paddr, tv[i].e_paddr);
      if (tv[i].e_write) chk($sformatf("v%0d_inst", i), {inst1, inst2}, {tv[i].e_i1, tv[i].e_i2});
    end
    redir = 0;

    // T3: three wait states on the transfer now in SETUP at 0x14
    wait_cfg = 3; stall_flg = 0;
    tick();
    k = 0;
    while (!write && k < 10) begin
      tick();
      k++;
    end
    chk("t3_latency", k, 4);
    tick();
    chk("t3_single_write", write, 0);

    // Redirect during SETUP of a waited transfer: discarded, then odd target
    wait_cfg = 2;
    tick();
    redir = 1; redir_addr = 16'h0106;
    tick();
    redir = 0;
    k = 0;
    while (psel && k < 10) begin
      tick();
      chk("ta_no_write", write, 0);
      k++;
    end
    chk("ta_bus_done", psel, 0);
    next_setup("ta", 16'h0104, 10);
    run_to_write("ta", 10);

    // Redirect while the pair is stalled in DELIVER: pair dropped
    stall_flg = 1; redir = 1; redir_addr = 16'h0040;
    tick();
    chk("tb_dropped", write, 0);
    next_setup("tb", 16'h0040, 10);
    run_to_write("tb", 10);

    // Redirect coincident with consumption: pair consumed, then redirect
    c0 = n_cons;
    stall_flg = 0; redir = 1; redir_addr = 16'h0082;
    tick();
    chk("tc_consumed", n_cons - c0, 1);
    chk("tc_write_low", write, 0);
    next_setup("tc", 16'h0080, 10);
    run_to_write("tc", 10);
    tick();

    // T5: wrap of the fetch address
    wait_cfg = 0;
    stall_flg = 1; redir = 1; redir_addr = 16'hFFFC;
    tick();
    next_setup("t5_top", 16'hFFFC, 10);
    run_to_write("t5", 10);
    next_setup("t5_wrap", 16'h0000, 10);
    run_to_write("t5_wrap", 10);
    tick();

    // Reset in the middle of a waited transfer drops psel at once
    wait_cfg = 3;
    stall_flg = 0;
    k = 0;
    while (!(psel && penable) && k < 10) begin
      tick();
      k++;
    end
    chk("rm_in_access", psel && penable, 1);
    rst = 1;
    tick();
    chk("rm_psel_drop", {psel, penable}, 2'b00);
    tick();
    rst = 0;
    wait_cfg = 0;
    next_setup("rm_restart", RESET_PC, 10);
    run_to_write("rm", 10);
    tick();

    // T6: slave error
    err_cfg = 1;
    do_reset();
`ifdef FETCH_ERR_EN
    stall_flg = 0;
    tick();
    tick();
    tick();
    chk("t6_no_write", write, 0);
    chk("t6_fetch_err", fetch_err, 1);
    for (int i = 0; i < 6; i++) begin
      redir = i[0]; redir_addr = 16'h0020;
      tick();
      chk("t6_locked", {psel, write, fetch_err}, 3'b001);
    end
    redir = 0;
    err_cfg = 0;
    do_reset();
    chk("t6_rst_clears", fetch_err, 0);
    // Error on a discarded transfer is ignored
    err_cfg = 1;
    stall_flg = 0;
    tick();
    redir = 1; redir_addr = 16'h0020;
    tick();
    redir = 0;
    tick();
    chk("t6_discard_err_ignored", fetch_err, 0);
    err_cfg = 0;
    next_setup("t6_after", 16'h0020, 10);
    run_to_write("t6_after", 10);
    tick();
`else
    run_to_write("t6_ignored", 10);
    chk("t6_fetch_err_tied", fetch_err, 0);
    tick();
    err_cfg = 0;
`endif

    // Randomized run against the program-counter model
    do_reset();
    c0 = n_cons;
    for (int i = 0; i < 3000; i++) begin
      if (!psel) wait_cfg = $urandom_range(0, 2);
      stall_flg  = ($urandom_range(0, 9) < 3);
      redir      = ($urandom_range(0, 19) == 0);
      redir_addr = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      tick();
    end
    redir = 0;
    chk("random_progress", (n_cons - c0) > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
